// File: rtl/idft_collect_pkg.sv
// rtl/idft_collect_pkg.sv - shared types and constants for the IDFT frame collector
package idft_collect_pkg;

    localparam int IDFT_COLLECT_FRAME_WORDS = 32;

    typedef enum logic [1:0] {EMPTY, FULL, DRAINING} bank_state_t;
    typedef enum logic [1:0] {IDLE, CAPTURE, DISCARD} cap_state_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/idft_collect_ram.sv
// rtl/idft_collect_ram.sv - two-bank frame RAM, one write port, registered read port
//
// Ports:
//   clk, rst          clock, async active-high reset (read register only)
//   i_we/i_waddr/i_wdata  write port, address MSB selects the bank
//   i_re/i_raddr      read enable / address; o_rdata holds when i_re is low
//   o_rdata           registered read data
module idft_collect_ram #(
    parameter  int FRAME_WORDS = 32,
    localparam int AW          = $clog2(FRAME_WORDS) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [63:0]   i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [63:0]   o_rdata
);

    logic [63:0] r_mem [2*FRAME_WORDS];
    logic [63:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read register only advances on i_re so a stalled beat stays put
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/idft_frame_collector.sv
// rtl/idft_frame_collector.sv - ping-pong capture of IDFT output frames, drained over valid/ready
//
// Captures FRAME_WORDS beats of {Y3,Y2,Y1,Y0} after each next_out into one of two
// banks and drains completed frames oldest-first, out_last on the final beat.
// Ports: clk, rst (async active-high); next_out, Y0..Y3 capture side;
// out_data/out_valid/out_ready/out_last drain side; flush, clear_status controls;
// overflow, frame_err sticky flags; frame_count, drop_count saturating counters.
// Build option: define IDFT_COLLECT_STATS_EN to enable the counters (else tied to 0).
module idft_frame_collector
    import idft_collect_pkg::*;
#(
    parameter int FRAME_WORDS = IDFT_COLLECT_FRAME_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        next_out,
    input  logic [15:0] Y0,
    input  logic [15:0] Y1,
    input  logic [15:0] Y2,
    input  logic [15:0] Y3,
    output logic [63:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    input  logic        flush,
    input  logic        clear_status,
    output logic        overflow,
    output logic        frame_err,
    output logic [15:0] frame_count,
    output logic [15:0] drop_count
);

    localparam int              IW       = $clog2(FRAME_WORDS);
    localparam logic [IW-1:0]   LAST_IDX = IW'(FRAME_WORDS - 1);

    cap_state_t    r_cap_state;
    logic [IW-1:0] r_wr_idx;
    logic          r_wr_bank;
    bank_state_t   r_bank_st [2];
    logic          r_first;
    logic          r_rd_active;
    logic          r_rd_bank;
    logic [IW-1:0] r_rd_idx;
    logic          r_valid;
    logic          r_last;
    logic          r_overflow;
    logic          r_frame_err;

    logic          w_next;
    logic          w_busy;
    logic          w_cap_last;
    logic          w_abort;
    logic          w_complete;
    logic          w_cap_hold;
    logic [1:0]    w_free;
    logic [1:0]    w_full;
    logic          w_drop;
    logic          w_sel;
    logic          w_start;
    logic          w_fire;
    logic          w_rd_bank;
    logic [IW-1:0] w_rd_idx;
    logic          w_hs;
    logic          w_release;
    logic [63:0]   w_rdata;

    assign w_next     = next_out && !flush;
    assign w_busy     = (r_cap_state != IDLE);
    assign w_cap_last = w_busy && (r_wr_idx == LAST_IDX);
    assign w_abort    = w_next && w_busy && !w_cap_last;
    assign w_complete = (r_cap_state == CAPTURE) && w_cap_last && !flush;

    // The bank under capture is unavailable unless this cycle aborts it
    assign w_cap_hold = (r_cap_state == CAPTURE) && !w_abort;
    assign w_free[0]  = (r_bank_st[0] == EMPTY) && !(w_cap_hold && !r_wr_bank);
    assign w_free[1]  = (r_bank_st[1] == EMPTY) && !(w_cap_hold && r_wr_bank);
    assign w_drop     = w_next && (w_free == 2'b00);

    assign w_full[0]  = (r_bank_st[0] == FULL);
    assign w_full[1]  = (r_bank_st[1] == FULL);
    assign w_sel      = (&w_full) ? r_first : w_full[1];

    // A new frame only starts once the previous out_last has been taken,
    // which yields exactly one idle cycle between frames
    assign w_start    = !r_rd_active && !r_valid && (|w_full);
    assign w_fire     = w_start || (r_rd_active && (!r_valid || out_ready));
    assign w_rd_bank  = w_start ? w_sel : r_rd_bank;
    assign w_rd_idx   = w_start ? '0 : r_rd_idx;
    assign w_hs       = r_valid && out_ready;
    assign w_release  = w_hs && r_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap_state <= IDLE;
            r_wr_idx    <= '0;
            r_wr_bank   <= 1'b0;
        end else if (flush) begin
            r_cap_state <= IDLE;
            r_wr_idx    <= '0;
        end else if (next_out) begin
            r_cap_state <= (w_free != 2'b00) ? CAPTURE : DISCARD;
            r_wr_bank   <= !w_free[0];
            r_wr_idx    <= '0;
        end else if (w_busy) begin
            if (w_cap_last) begin
                r_cap_state <= IDLE;
            end
            r_wr_idx <= r_wr_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bank_st[0] <= EMPTY;
            r_bank_st[1] <= EMPTY;
            r_first      <= 1'b0;
        end else if (flush) begin
            r_bank_st[0] <= EMPTY;
            r_bank_st[1] <= EMPTY;
        end else begin
            if (w_complete) begin
                r_bank_st[r_wr_bank] <= FULL;
                if (r_bank_st[~r_wr_bank] != FULL) begin
                    r_first <= r_wr_bank;
                end
            end
            if (w_start) begin
                r_bank_st[w_sel] <= DRAINING;
            end
            if (w_release) begin
                r_bank_st[r_rd_bank] <= EMPTY;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_active <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_rd_idx    <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
        end else if (flush) begin
            r_rd_active <= 1'b0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
        end else if (w_fire) begin
            r_valid     <= 1'b1;
            r_last      <= (w_rd_idx == LAST_IDX);
            r_rd_active <= (w_rd_idx != LAST_IDX);
            r_rd_idx    <= w_rd_idx + 1'b1;
            r_rd_bank   <= w_rd_bank;
        end else if (w_hs) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (clear_status) begin
                r_overflow  <= 1'b0;
                r_frame_err <= 1'b0;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_abort) begin
                r_frame_err <= 1'b1;
            end
        end
    end

`ifdef IDFT_COLLECT_STATS_EN
    logic [15:0] r_frame_count;
    logic [15:0] r_drop_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_count <= '0;
            r_drop_count  <= '0;
        end else begin
            if (w_complete) begin
                r_frame_count <= clear_status ? 16'd1 : sat_inc16(r_frame_count);
            end else if (clear_status) begin
                r_frame_count <= '0;
            end
            if (w_drop) begin
                r_drop_count <= clear_status ? 16'd1 : sat_inc16(r_drop_count);
            end else if (clear_status) begin
                r_drop_count <= '0;
            end
        end
    end

    assign frame_count = r_frame_count;
    assign drop_count  = r_drop_count;
`else
    assign frame_count = 16'h0;
    assign drop_count  = 16'h0;
`endif

    idft_collect_ram #(
        .FRAME_WORDS (FRAME_WORDS)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (r_cap_state == CAPTURE),
        .i_waddr ({r_wr_bank, r_wr_idx}),
        .i_wdata ({Y3, Y2, Y1, Y0}),
        .i_re    (w_fire),
        .i_raddr ({w_rd_bank, w_rd_idx}),
        .o_rdata (w_rdata)
    );

    assign out_data  = w_rdata;
    assign out_valid = r_valid;
    assign out_last  = r_last;
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_idft_frame_collector.sv
// tb/tb_idft_frame_collector.sv - self-checking bench for idft_frame_collector
module tb_idft_frame_collector;

    localparam int FW = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        next_out = 1'b0;
    logic [15:0] Y0 = '0, Y1 = '0, Y2 = '0, Y3 = '0;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    logic        clear_status = 1'b0;
    logic [63:0] out_data;
    logic        out_valid, out_last, overflow, frame_err;
    logic [15:0] frame_count, drop_count;

    idft_frame_collector #(.FRAME_WORDS(FW)) dut (
        .clk(clk), .rst(rst), .next_out(next_out),
        .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .flush(flush), .clear_status(clear_status),
        .overflow(overflow), .frame_err(frame_err),
        .frame_count(frame_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: completed frames are a flat word queue, one bank per frame
    logic [63:0] exp_q [$];
    logic [63:0] m_buf [$];
    int          m_mode = 0;   // 0 idle, 1 storing a frame, 2 skipping a dropped frame
    int          m_cnt = 0;
    logic        m_ovf = 0, m_ferr = 0;
    logic [15:0] m_fc = 0, m_dc = 0;
    logic        p_valid = 0, p_ready = 0, p_flush = 0, p_last = 0;
    logic [63:0] p_data = 0;
    logic [63:0] hs_q [$];
    int          hs_cyc [$];
    logic        hs_last [$];
    int          first_vld = -1;

    function automatic logic [15:0] exp_cnt(input logic [15:0] v);
`ifdef IDFT_COLLECT_STATS_EN
        return v;
`else
        return 16'h0 & v;
`endif
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_valid", out_valid, 0);
            chk("rst_last", out_last, 0);
            chk("rst_data", out_data, 0);
            chk("rst_flags", {overflow, frame_err}, 0);
            chk("rst_counts", {frame_count, drop_count}, 0);
            exp_q.delete(); m_buf.delete();
            m_mode = 0; m_cnt = 0; m_ovf = 0; m_ferr = 0; m_fc = 0; m_dc = 0;
            p_valid = 0; p_flush = 0;
        end else begin
            int occ;
            int completed;
            occ = (exp_q.size() + FW - 1) / FW;
            completed = 0;
            chk("overflow", overflow, m_ovf);
            chk("frame_err", frame_err, m_ferr);
            chk("frame_count", frame_count, exp_cnt(m_fc));
            chk("drop_count", drop_count, exp_cnt(m_dc));
            if (p_flush) begin
                chk("flush_valid", out_valid, 0);
            end else if (p_valid && !p_ready) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, p_data);
                chk("hold_last", out_last, p_last);
            end
            if (out_valid && first_vld < 0) first_vld = cyc;
            if (out_valid && out_ready) begin
                chk("beat_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    chk("beat_data", out_data, exp_q[0]);
                    chk("beat_last", out_last, (exp_q.size() % FW) == 1);
                    void'(exp_q.pop_front());
                end
                hs_q.push_back(out_data);
                hs_cyc.push_back(cyc);
                hs_last.push_back(out_last);
            end
            // advance the model across the coming edge
            if (clear_status) begin
                m_ovf = 0; m_ferr = 0; m_fc = 0; m_dc = 0;
            end
            if (flush) begin
                exp_q.delete(); m_buf.delete(); m_mode = 0;
            end else begin
                if (m_mode != 0) begin
                    if (m_mode == 1) m_buf.push_back({Y3, Y2, Y1, Y0});
                    m_cnt++;
                    if (m_cnt == FW) begin
                        if (m_mode == 1) begin
                            foreach (m_buf[i]) exp_q.push_back(m_buf[i]);
                            completed = 1;
                            if (m_fc != 16'hFFFF) m_fc++;
                        end
                        m_mode = 0;
                    end else if (next_out) begin
                        m_ferr = 1;
                        m_mode = 0;
                    end
                end
                if (next_out) begin
                    m_cnt = 0;
                    m_buf.delete();
                    if (occ + completed < 2) begin
                        m_mode = 1;
                    end else begin
                        m_mode = 2;
                        m_ovf = 1;
                        if (m_dc != 16'hFFFF) m_dc++;
                    end
                end
            end
            p_valid = out_valid; p_ready = out_ready; p_flush = flush;
            p_data = out_data; p_last = out_last;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_y(input logic [15:0] v);
        Y0 = v; Y1 = v; Y2 = v; Y3 = v;
    endtask

    task automatic start();
        next_out = 1'b1;
        step();
        next_out = 1'b0;
    endtask

    task automatic frame_data(input int first, input int n, input bit next_at_end);
        for (int i = 0; i < n; i++) begin
            set_y(16'(first + i));
            next_out = next_at_end && (i == n - 1);
            step();
        end
        next_out = 1'b0;
    endtask

    task automatic wait_hs(input int n, input int budget, input bit toggle);
        int k = 0;
        while (hs_q.size() < n && k < budget) begin
            if (toggle) out_ready = ~out_ready;
            step();
            k++;
        end
        chk("hs_within_budget", hs_q.size() >= n, 1);
    endtask

    task automatic clr_hs();
        hs_q.delete(); hs_cyc.delete(); hs_last.delete();
        first_vld = -1;
    endtask

    int t_next;
    int gap;
    int target;

    initial begin
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("idle_valid", out_valid, 0);

        // single frame, ready high
        out_ready = 1'b1;
        clr_hs();
        t_next = cyc;
        start();
        frame_data(0, FW, 0);
        wait_hs(FW, 100, 0);
        chk("t1_latency", first_vld - t_next, 34);
        chk("t1_first", hs_q[0], 64'h0);
        chk("t1_beat31", hs_q[31], 64'h001f_001f_001f_001f);
        chk("t1_last", hs_last[31], 1);
        chk("t1_not_last", hs_last[30], 0);

        // three back-to-back frames with consumer stalled
        out_ready = 1'b0;
        clear_status = 1'b1; step(); clear_status = 1'b0;
        clr_hs();
        start();
        frame_data(0, FW, 1);
        frame_data(32, FW, 1);
        frame_data(64, FW, 0);
        repeat (4) step();
        chk("t2_overflow", overflow, 1);
        chk("t2_drops", drop_count, exp_cnt(16'd1));
        chk("t2_frames", frame_count, exp_cnt(16'd2));
        chk("t2_stalled", hs_q.size(), 0);
        out_ready = 1'b1;
        wait_hs(2 * FW, 200, 0);
        repeat (40) step();
        chk("t2_total", hs_q.size(), 2 * FW);
        chk("t2_f0", hs_q[0], 64'h0);
        chk("t2_f1", hs_q[32], 64'h0020_0020_0020_0020);
        chk("t2_burst", hs_cyc[31] - hs_cyc[0], 31);
        chk("t2_bubble", hs_cyc[32] - hs_cyc[31], 2);

        // abort at capture beat 10
        clr_hs();
        start();
        frame_data(100, 11, 1);
        frame_data(0, FW, 0);
        wait_hs(FW, 100, 0);
        repeat (40) step();
        chk("t3_frame_err", frame_err, 1);
        chk("t3_total", hs_q.size(), FW);
        chk("t3_first", hs_q[0], 64'h0);
        clear_status = 1'b1; step(); clear_status = 1'b0;
        chk("t3_cleared", {overflow, frame_err, frame_count, drop_count}, 0);

        // ready toggling every cycle
        clr_hs();
        out_ready = 1'b0;
        start();
        frame_data(200, FW, 0);
        wait_hs(FW, 200, 1);
        out_ready = 1'b0;
        repeat (10) step();
        chk("t4_total", hs_q.size(), FW);
        chk("t4_end", hs_q[31], 64'h00e7_00e7_00e7_00e7);

        // flush mid-drain
        clr_hs();
        out_ready = 1'b1;
        start();
        frame_data(300, FW, 0);
        wait_hs(5, 100, 0);
        out_ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t5_flush_valid", out_valid, 0);
        out_ready = 1'b1;
        clr_hs();
        start();
        frame_data(400, FW, 0);
        wait_hs(FW, 100, 0);
        repeat (40) step();
        chk("t5_total", hs_q.size(), FW);
        chk("t5_first", hs_q[0], 64'h0190_0190_0190_0190);

        // async reset mid-capture
        clr_hs();
        start();
        frame_data(500, 10, 0);
        #2 rst = 1'b1;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_counts", {frame_count, drop_count}, 0);
        chk("t6_flags", {overflow, frame_err}, 0);
        step();
        rst = 1'b0;
        repeat (60) step();
        chk("t6_nothing_out", hs_q.size(), 0);

        // randomized traffic
        gap = 0;
        target = 0;
        for (int c = 0; c < 4000; c++) begin
            Y0 = 16'($urandom); Y1 = 16'($urandom); Y2 = 16'($urandom); Y3 = 16'($urandom);
            out_ready = ($urandom_range(0, 99) < 60);
            flush = ($urandom_range(0, 299) == 0);
            clear_status = ($urandom_range(0, 99) < 2);
            next_out = (gap == target);
            if (next_out) begin
                gap = 0;
                case ($urandom_range(0, 9))
                    0:       target = $urandom_range(3, FW - 1);
                    1, 2, 3: target = FW;
                    default: target = $urandom_range(FW + 1, FW + 20);
                endcase
            end else begin
                gap++;
            end
            step();
        end
        next_out = 1'b0;
        flush = 1'b0;
        clear_status = 1'b0;
        out_ready = 1'b1;
        repeat (150) step();
        chk("final_drained", exp_q.size(), 0);
        chk("final_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
